shift_regs_ctrl: RTL

- Sequencer for the Shift_Regs line-window buffer in the conv input path.
- Given a tile (three input rows, a column range, kernel k, stride s, west/east padding), it:
  - fetches 32-pixel row words from the feature-map buffer one at a time;
  - presents each word to Shift_Regs with the row and register index ranges and the add-end flags;
  - then sweeps the kernel windows across the loaded registers for the PE array.
- Sits between the tile scheduler (start/done) and the feature-map buffer plus Shift_Regs.

---
 rtl/shift_regs_ctrl_pkg.sv | 26 ++
 rtl/shift_regs_ctrl_win_sweep.sv | 39 +++
 rtl/shift_regs_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_regs_ctrl_pkg.sv
// Shared constants, FSM state encoding and latched tile configuration
// for the Shift_Regs line-window sequencer.
package shift_regs_ctrl_pkg;

  localparam int WORD_PIX = 32;
  localparam int PIX_W    = 8;
  localparam int REG_NUM  = 70;
  localparam int ROW_W    = WORD_PIX * PIX_W;
  localparam int SLAB_W   = 2 * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_LOAD, S_SWEEP
  } state_t;

  typedef struct packed {
    logic [3:0]  k;
    logic [3:0]  s;
    logic [3:0]  west;
    logic [3:0]  east;
    logic [3:0]  slab;
    logic [15:0] col_start;
    logic [15:0] width;
    logic [15:0] row1;
  } cfg_t;

endpackage

// File: rtl/shift_regs_ctrl_win_sweep.sv
// Kernel-window sweep across the loaded registers: position counter
// plus the valid/ready handshake towards the PE array.
module shift_regs_win_sweep (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] d,
  input  logic [3:0]  k,
  input  logic [3:0]  s,
  input  logic        win_ready,
  output logic        win_valid,
  output logic [15:0] win_reg_idx,
  output logic        win_last,
  output logic        fin
);

  logic        active_q;
  logic [15:0] p_q;

  // position advances by stride on every consumed window; last one ends the sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      p_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      p_q      <= '0;
    end else if (active_q && win_ready) begin
      if (win_last) active_q <= 1'b0;
      else          p_q      <= p_q + 16'(s);
    end
  end

  assign win_valid   = active_q;
  assign win_reg_idx = active_q ? p_q + 16'd1 : '0;
  assign win_last    = active_q && ((p_q + 16'(s) + 16'(k)) > d);
  assign fin         = active_q && win_ready && win_last;

endmodule

// File: rtl/shift_regs_ctrl.sv
// Shift_Regs sequencer: checks tile config, fetches row words one at a
// time, presents each for one LOAD cycle, then sweeps kernel windows.
// Optional slab support is compiled in with SHIFT_REGS_SLAB_EN.
module shift_regs_ctrl
  import shift_regs_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cfg_k,
  input  logic [3:0]        cfg_s,
  input  logic [3:0]        cfg_west_pad,
  input  logic [3:0]        cfg_east_pad,
  input  logic [3:0]        cfg_slab_num,
  input  logic [15:0]       cfg_col_start,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_row1_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [15:0]       rd_col,
  input  logic              rd_data_valid,
  input  logic [ROW_W-1:0]  rd_row1_pixels,
  input  logic [ROW_W-1:0]  rd_row2_pixels,
  input  logic [ROW_W-1:0]  rd_row3_pixels,
  input  logic [SLAB_W-1:0] rd_slab1,
  input  logic [SLAB_W-1:0] rd_slab2,
  input  logic [SLAB_W-1:0] rd_slab3,
  output logic [ROW_W-1:0]  sr_row1_pixels_32,
  output logic [ROW_W-1:0]  sr_row2_pixels_32,
  output logic [ROW_W-1:0]  sr_row3_pixels_32,
  output logic [SLAB_W-1:0] sr_row1_slab_2,
  output logic [SLAB_W-1:0] sr_row2_slab_2,
  output logic [SLAB_W-1:0] sr_row3_slab_2,
  output logic [15:0]       sr_row1_idx,
  output logic [15:0]       sr_row2_idx,
  output logic [15:0]       sr_row3_idx,
  output logic [15:0]       sr_row_start_idx,
  output logic [15:0]       sr_row_end_idx,
  output logic [15:0]       sr_reg_start_idx,
  output logic [15:0]       sr_reg_end_idx,
  output logic [3:0]        sr_west_pad,
  output logic [3:0]        sr_slab_num,
  output logic [3:0]        sr_east_pad,
  output logic [3:0]        sr_k,
  output logic [3:0]        sr_s,
  output logic              sr_conv_min_pixels_add_end,
  output logic              sr_conv_pixels_add_end,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [15:0]       win_reg_idx,
  output logic              win_last
);

  state_t             state_q, state_n;
  cfg_t               cfg_in, cfg_q;
  logic [15:0]        w_q;
  logic [2:0][ROW_W-1:0] row_q;
  logic               min_q, min_seen_q, done_q, err_q;
  logic [15:0]        rs_q, re_q, gs_q, ge_q;
  logic [3:0]         wp_q, sl_q, ep_q;
  logic               done_set, err_set, sweep_go, sweep_fin, is_load;

  // widened so an oversized width cannot wrap past the legality check
  logic [17:0] d_full;
  logic [16:0] nwords;
  logic [15:0] w_pix, base_off, row_base, reg_start, reg_lim, reg_end;
  logic        last_word, cfg_bad, min_hit;

  // configuration snapshot; slab is forced to zero unless the feature is built in
  always_comb begin
    cfg_in           = '0;
    cfg_in.k         = cfg_k;
    cfg_in.s         = cfg_s;
    cfg_in.west      = cfg_west_pad;
    cfg_in.east      = cfg_east_pad;
`ifdef SHIFT_REGS_SLAB_EN
    cfg_in.slab      = cfg_slab_num;
`else
    cfg_in.slab      = 4'd0;
`endif
    cfg_in.col_start = cfg_col_start;
    cfg_in.width     = cfg_width;
    cfg_in.row1      = cfg_row1_idx;
  end

  assign d_full    = 18'(cfg_q.west) + 18'(cfg_q.slab) + 18'(cfg_q.width) + 18'(cfg_q.east);
  assign nwords    = (17'(cfg_q.width) + 17'd31) >> 5;
  assign last_word = (17'(w_q) + 17'd1) >= nwords;
  assign cfg_bad   = (d_full > 18'(REG_NUM)) || (cfg_q.k == 4'd0) ||
                     (cfg_q.s == 4'd0) || (d_full < 18'(cfg_q.k));
  assign w_pix     = w_q << 5;
  assign base_off  = 16'(cfg_q.west) + 16'(cfg_q.slab);
  assign row_base  = cfg_q.col_start + w_pix;
  assign reg_start = 16'd1 + base_off + w_pix;
  assign reg_lim   = base_off + cfg_q.width;
  assign reg_end   = ((reg_start + 16'd31) < reg_lim) ? reg_start + 16'd31 : reg_lim;
  assign min_hit   = (reg_end + (last_word ? 16'(cfg_q.east) : 16'd0)) >= 16'(cfg_q.k);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // next state and handshake strobes
  always_comb begin
    state_n      = state_q;
    rd_req_valid = 1'b0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    sweep_go     = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_n = S_CHECK;
      S_CHECK: begin
        if (cfg_bad) begin
          state_n  = S_IDLE;
          done_set = 1'b1;
          err_set  = 1'b1;
        end else begin
          state_n  = S_REQ;
        end
      end
      S_REQ: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) state_n = S_WAIT;
      end
      S_WAIT:  if (rd_data_valid) state_n = S_LOAD;
      S_LOAD: begin
        if (last_word) begin
          state_n  = S_SWEEP;
          sweep_go = 1'b1;
        end else begin
          state_n  = S_REQ;
        end
      end
      S_SWEEP: begin
        if (sweep_fin) begin
          state_n  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // config latch, word counter and LOAD-cycle capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q      <= '0;
      w_q        <= '0;
      row_q      <= '0;
      min_q      <= 1'b0;
      min_seen_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rs_q       <= '0;
      re_q       <= '0;
      gs_q       <= '0;
      ge_q       <= '0;
      wp_q       <= '0;
      sl_q       <= '0;
      ep_q       <= '0;
    end else begin
      done_q <= done_set;
      err_q  <= err_set;
      if (state_q == S_IDLE && start) cfg_q <= cfg_in;
      if (state_q == S_CHECK) begin
        w_q        <= '0;
        min_seen_q <= 1'b0;
      end
      if (state_q == S_WAIT && rd_data_valid) begin
        row_q <= {rd_row3_pixels, rd_row2_pixels, rd_row1_pixels};
        rs_q  <= row_base;
        re_q  <= row_base + 16'd31;
        gs_q  <= reg_start;
        ge_q  <= reg_end;
        wp_q  <= (w_q == '0) ? cfg_q.west : 4'd0;
        sl_q  <= (w_q == '0) ? cfg_q.slab : 4'd0;
        ep_q  <= last_word ? cfg_q.east : 4'd0;
        min_q <= min_hit && !min_seen_q;
        if (min_hit) min_seen_q <= 1'b1;
      end
      if (state_q == S_LOAD && !last_word) w_q <= w_q + 16'd1;
    end
  end

  shift_regs_win_sweep u_sweep (
    .clk         (clk),
    .reset       (reset),
    .start       (sweep_go),
    .d           (d_full[15:0]),
    .k           (cfg_q.k),
    .s           (cfg_q.s),
    .win_ready   (win_ready),
    .win_valid   (win_valid),
    .win_reg_idx (win_reg_idx),
    .win_last    (win_last),
    .fin         (sweep_fin)
  );

  assign is_load  = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign cfg_err  = err_q;
  assign rd_col   = rd_req_valid ? row_base : '0;

  assign sr_row1_pixels_32 = is_load ? row_q[0] : '0;
  assign sr_row2_pixels_32 = is_load ? row_q[1] : '0;
  assign sr_row3_pixels_32 = is_load ? row_q[2] : '0;

`ifdef SHIFT_REGS_SLAB_EN
  logic [2:0][SLAB_W-1:0] slab_q;

  // slab pixels ride along with word 0 only
  always_ff @(posedge clk) begin
    if (reset)                                                     slab_q <= '0;
    else if (state_q == S_WAIT && rd_data_valid && w_q == '0)      slab_q <= {rd_slab3, rd_slab2, rd_slab1};
  end

  assign sr_row1_slab_2 = (is_load && w_q == '0) ? slab_q[0] : '0;
  assign sr_row2_slab_2 = (is_load && w_q == '0) ? slab_q[1] : '0;
  assign sr_row3_slab_2 = (is_load && w_q == '0) ? slab_q[2] : '0;
`else
  logic unused_slab;
  assign unused_slab    = ^{cfg_slab_num, rd_slab1, rd_slab2, rd_slab3};
  assign sr_row1_slab_2 = '0;
  assign sr_row2_slab_2 = '0;
  assign sr_row3_slab_2 = '0;
`endif

  assign sr_row1_idx      = cfg_q.row1;
  assign sr_row2_idx      = cfg_q.row1 + 16'd1;
  assign sr_row3_idx      = cfg_q.row1 + 16'd2;
  assign sr_row_start_idx = rs_q;
  assign sr_row_end_idx   = re_q;
  assign sr_reg_start_idx = gs_q;
  assign sr_reg_end_idx   = ge_q;
  assign sr_west_pad      = wp_q;
  assign sr_slab_num      = sl_q;
  assign sr_east_pad      = ep_q;
  assign sr_k             = cfg_q.k;
  assign sr_s             = cfg_q.s;
  assign sr_conv_min_pixels_add_end = is_load && min_q;
  assign sr_conv_pixels_add_end     = is_load && last_word;

endmodule
